// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;
  typedef logic [31:0] regval_t;

  localparam regval_t NOP           = 32'h8000_0000;
  localparam int      DEFAULT_DEPTH = 4;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    regval_t pc;
    regval_t instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with push/pop/clear; head is read combinationally.
// Clear wins over push and pop in the same cycle.
module fetch_queue #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_dat,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [W-1:0]  o_head_dat,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_count    = r_count;
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == DEPTH[CW-1:0]);
  assign o_head_dat = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  // A push into a full queue is allowed only when the head leaves in the same cycle.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: in-order imem requests, prefetch buffer of {pc, word}, redirect/flush drop logic.
// Buffered entries plus outstanding requests never exceed DEPTH; decode stalls with hold.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter regval_t RESET_PC = 32'h0,
  parameter int      DEPTH    = DEFAULT_DEPTH
) (
  input  logic    clock,
  input  logic    reset_n,
  output logic    imem_req,
  output regval_t imem_addr,
  input  logic    imem_ready,
  input  logic    imem_rvalid,
  input  regval_t imem_rdata,
  input  logic    redirect_valid,
  input  regval_t redirect_pc,
  input  logic    is_pc_changing,
  input  logic    early_flush,
  output logic    is_valid,
  input  logic    hold,
  output regval_t pc,
  output regval_t instruction
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  regval_t       r_fetch_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_count;

  logic          w_flush;
  logic          w_accept;
  logic          w_keep_resp;
  logic          w_room;
  logic [CW:0]   w_occupancy;
  regval_t       w_pend_pc;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic [CW-1:0] w_buf_count;
  logic          w_buf_empty;
  logic          w_buf_full;
  logic [CW-1:0] w_pend_count;
  logic          w_pend_full;
  logic          w_pend_empty;
  logic          w_unused;

  assign w_flush     = redirect_valid || early_flush;
  assign w_accept    = imem_req && imem_ready;
  assign w_occupancy = {1'b0, w_buf_count} + {1'b0, r_outstanding};
  assign w_room      = (w_occupancy < DEPTH[CW:0]);
  // Responses during a flush belong to the discarded stream, as do those still owed by drop_count.
  assign w_keep_resp = imem_rvalid && (r_drop_count == '0) && !w_flush;
  assign imem_addr   = r_fetch_pc;

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = RUN;
    end else if (early_flush || is_pc_changing) begin
      w_state_nxt = WAIT;
    end else if (r_state == RUN && w_room && reset_n) begin
      imem_req = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(imem_rvalid);
      if (redirect_valid)  r_fetch_pc <= redirect_pc;
      else if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_flush)                                 r_drop_count <= r_outstanding - CW'(imem_rvalid);
      else if (imem_rvalid && r_drop_count != '0)  r_drop_count <= r_drop_count - 1'b1;
    end
  end

  fetch_queue #(.W(32), .DEPTH(DEPTH)) u_pend_q (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push     (w_accept),
    .i_push_dat (r_fetch_pc),
    .i_pop      (imem_rvalid),
    .i_clear    (1'b0),
    .o_head_dat (w_pend_pc),
    .o_count    (w_pend_count),
    .o_full     (w_pend_full),
    .o_empty    (w_pend_empty)
  );

  assign w_push_entry = '{pc: w_pend_pc, instr: imem_rdata};

  fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_buf_q (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_push     (w_keep_resp),
    .i_push_dat (w_push_entry),
    .i_pop      (!hold),
    .i_clear    (w_flush),
    .o_head_dat (w_head),
    .o_count    (w_buf_count),
    .o_full     (w_buf_full),
    .o_empty    (w_buf_empty)
  );

  assign is_valid    = !w_buf_empty;
  assign pc          = is_valid ? w_head.pc    : '0;
  assign instruction = is_valid ? w_head.instr : NOP;

  assign w_unused = &{1'b0, w_pend_count, w_pend_full, w_pend_empty, w_buf_full};
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage with a queue-based reference model of the fetched stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] PAT   = 32'hA5A5_A5A5;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, is_pc_changing, early_flush, hold, is_valid;
  logic [31:0] redirect_pc, pc, instruction;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) u_dut (
    .clock(clock), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .is_pc_changing(is_pc_changing),
    .early_flush(early_flush), .is_valid(is_valid), .hold(hold), .pc(pc), .instruction(instruction)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
    .clock(clock), .reset_n(reset_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rvalid(1'b0), .imem_rdata(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .is_pc_changing(1'b0),
    .early_flush(1'b0), .is_valid(w_valid), .hold(1'b0), .pc(w_pc), .instruction(w_instr)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Memory environment: fixed latency plus optional random extra, responses kept in order.
  int          cyc = 0;
  int          lat = 1;
  int          extra_max = 0;
  int          last_due;
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  // Reference model: addresses accepted since the last flush, how many of them have returned.
  logic [31:0] exp_q[$];
  int          m_arrived, m_drop, m_out;
  logic        m_run;
  logic [31:0] m_addr;

  // Observations from the latest cycle.
  logic        g_acc, g_valid, g_req;
  logic [31:0] g_pc, g_instr, g_addr;

  task automatic model_reset();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    m_arrived = 0; m_drop = 0; m_out = 0; m_run = 1'b1; m_addr = 32'h0; last_due = -1;
  endtask

  task automatic tick();
    logic exp_valid, exp_req, acc;
    int   due;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr_q[0] ^ PAT;
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    #1;
    g_valid = is_valid; g_pc = pc; g_instr = instruction; g_req = imem_req; g_addr = imem_addr;
    exp_valid = (m_arrived > 0);
    checks++;
    if (is_valid !== exp_valid) begin
      errors++; $display("FAIL is_valid cyc=%0d got=%b exp=%b", cyc, is_valid, exp_valid);
    end else if (exp_valid) begin
      checks++;
      if (pc !== exp_q[0] || instruction !== (exp_q[0] ^ PAT)) begin
        errors++; $display("FAIL out_pair cyc=%0d got=%h/%h exp=%h/%h", cyc, pc, instruction, exp_q[0], exp_q[0] ^ PAT);
      end
    end else begin
      checks++;
      if (instruction !== NOP) begin
        errors++; $display("FAIL nop cyc=%0d got=%h exp=%h", cyc, instruction, NOP);
      end
    end
    exp_req = m_run && !redirect_valid && !early_flush && !is_pc_changing && (m_arrived + m_out < DEPTH);
    checks++;
    if (imem_req !== exp_req) begin
      errors++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
    end
    if (imem_req === 1'b1) begin
      checks++;
      if (imem_addr !== m_addr) begin
        errors++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_addr);
      end
    end
    acc   = (imem_req === 1'b1) && imem_ready;
    g_acc = acc;
    if (acc) begin
      due = cyc + lat + $urandom_range(0, extra_max);
      if (due <= last_due) due = last_due + 1;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(due);
      last_due = due;
    end
    if (redirect_valid || early_flush) begin
      m_drop = m_out - int'(imem_rvalid);
      exp_q.delete();
      m_arrived = 0;
      m_run = redirect_valid;
      if (redirect_valid) m_addr = redirect_pc;
    end else begin
      if (is_pc_changing) m_run = 1'b0;
      if (imem_rvalid) begin
        if (m_drop > 0) m_drop--;
        else m_arrived++;
      end
      if (exp_valid && !hold) begin
        void'(exp_q.pop_front());
        m_arrived--;
      end
      if (acc) begin
        exp_q.push_back(m_addr);
        m_addr = m_addr + 32'd4;
      end
    end
    m_out = m_out + int'(acc) - int'(imem_rvalid);
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; is_pc_changing = 1'b0;
    early_flush = 1'b0; hold = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; is_pc_changing = 1'b0; early_flush = 1'b0; hold = 1'b0;
    #2;
    checks++;
    if (is_valid !== 1'b0 || instruction !== NOP || pc !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got v=%b pc=%h i=%h exp v=0 pc=0 i=%h", is_valid, pc, instruction, NOP);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_imem got req=%b addr=%h exp req=0 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    int first_acc = -1, first_valid = -1, nvalid = 0;
    do_reset();
    lat = 1; extra_max = 0; imem_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (g_acc && first_acc < 0) first_acc = k;
      if (g_valid && first_valid < 0) first_valid = k;
      if (k >= 2 && g_valid) nvalid++;
    end
    checks++;
    if (first_acc != 0 || first_valid != 2) begin
      errors++; $display("FAIL first_latency got acc=%0d valid=%0d exp acc=0 valid=2", first_acc, first_valid);
    end
    checks++;
    if (nvalid != 18) begin
      errors++; $display("FAIL throughput got=%0d exp=18", nvalid);
    end
  endtask

  task automatic test_hold();
    int          nacc = 0;
    logic [31:0] snap_pc = 32'h0;
    do_reset();
    lat = 1; extra_max = 0; imem_ready = 1'b1; hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (g_acc) nacc++;
      if (k == 2) snap_pc = g_pc;
    end
    checks++;
    if (nacc != DEPTH) begin
      errors++; $display("FAIL hold_issue got=%0d exp=%0d", nacc, DEPTH);
    end
    checks++;
    if (g_valid !== 1'b1 || g_pc !== snap_pc || g_pc !== 32'h0) begin
      errors++; $display("FAIL hold_frozen got v=%b pc=%h exp v=1 pc=0", g_valid, g_pc);
    end
    hold = 1'b0;
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic test_redirect();
    int seen = 0;
    do_reset();
    lat = 3; extra_max = 0; imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (g_req !== 1'b1 || g_addr !== 32'h100 || g_valid !== 1'b0 || g_instr !== NOP) begin
      errors++; $display("FAIL redirect_next got req=%b addr=%h v=%b i=%h exp 1/100/0/%h", g_req, g_addr, g_valid, g_instr, NOP);
    end
    for (int k = 0; k < 20 && seen == 0; k++) begin
      tick();
      if (g_valid) begin
        seen = 1;
        checks++;
        if (g_pc !== 32'h100) begin
          errors++; $display("FAIL redirect_first_pc got=%h exp=00000100", g_pc);
        end
      end
    end
    if (seen == 0) begin
      checks++; errors++; $display("FAIL redirect_timeout got=none exp=valid");
    end
  endtask

  task automatic test_pc_changing();
    int seen = 0, bad = 0;
    do_reset();
    lat = 2; extra_max = 0; imem_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    is_pc_changing = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (g_req !== 1'b0) bad++;
    end
    early_flush = 1'b1;
    tick();
    early_flush = 1'b0; is_pc_changing = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (g_req !== 1'b0 || g_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wait_no_issue got=%0d bad cycles exp=0", bad);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if (g_req !== 1'b1 || g_addr !== 32'h200) begin
      errors++; $display("FAIL resume_addr got req=%b addr=%h exp 1/00000200", g_req, g_addr);
    end
    for (int k = 0; k < 20 && seen == 0; k++) begin
      tick();
      if (g_valid) begin
        seen = 1;
        checks++;
        if (g_pc !== 32'h200) begin
          errors++; $display("FAIL resume_pc got=%h exp=00000200", g_pc);
        end
      end
    end
    if (seen == 0) begin
      checks++; errors++; $display("FAIL resume_timeout got=none exp=valid");
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a = 32'hFFFF_FFF8;
    do_reset();
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (w_req !== 1'b1 || w_addr !== a) begin
        errors++; $display("FAIL wrap_addr k=%0d got req=%b addr=%h exp 1/%h", k, w_req, w_addr, a);
      end
      a = a + 32'd4;
      tick();
    end
    #1;
    checks++;
    if (w_req !== 1'b0 || w_valid !== 1'b0 || w_instr !== NOP || w_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_full got req=%b v=%b pc=%h i=%h exp 0/0/0/%h", w_req, w_valid, w_pc, w_instr, NOP);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 1; extra_max = 0; imem_ready = 1'b1; hold = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (g_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid got=%b exp=1", g_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (is_valid !== 1'b0 || instruction !== NOP || pc !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL async_reset got v=%b pc=%h i=%h req=%b addr=%h", is_valid, pc, instruction, imem_req, imem_addr);
    end
    @(negedge clock);
    model_reset();
    hold = 1'b0;
    reset_n = 1'b1;
    tick();
    checks++;
    if (g_req !== 1'b1 || g_addr !== 32'h0) begin
      errors++; $display("FAIL restart got req=%b addr=%h exp 1/00000000", g_req, g_addr);
    end
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_random();
    logic [31:0] r;
    int          pops = 0;
    do_reset();
    lat = 2; extra_max = 2;
    for (int k = 0; k < 3000; k++) begin
      imem_ready     = ($urandom_range(0, 3) != 0);
      hold           = ($urandom_range(0, 3) == 0);
      is_pc_changing = ($urandom_range(0, 49) == 0);
      early_flush    = ($urandom_range(0, 79) == 0);
      redirect_valid = ($urandom_range(0, 63) == 0) || (!m_run && $urandom_range(0, 7) == 0);
      r = $urandom;
      redirect_pc = {r[31:2], 2'b00};
      tick();
      if (g_valid && !hold) pops++;
    end
    redirect_valid = 1'b0; early_flush = 1'b0; is_pc_changing = 1'b0; hold = 1'b0;
    checks++;
    if (pops < 200) begin
      errors++; $display("FAIL random_activity got=%0d exp>=200", pops);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold();
    test_redirect();
    test_pc_changing();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
